faxi_burst_seq: RTL and testbench

Burst sequencer for the AXI slave address path: accepts one AW/AR-style burst command via a valid/ready handshake, latches it, and emits one beat address per cycle on a downstream valid/ready stream until the burst's last beat is consumed. Per-beat next-address arithmetic follows the slave's FIXED/INCR/WRAP rules and is computed internally. Sits between the slave's address-channel front end and its read-data or write-data beat engine.

---
 rtl/faxi_burst_seq_if.sv | 32 +++
 rtl/faxi_burst_seq.sv | 125 ++++++++++++
 tb/tb_faxi_burst_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/faxi_burst_seq_if.sv
// Command and beat-address handshake bundle for faxi_burst_seq.
// The slave modport is the sequencer side; the master modport is the front end plus beat consumer.
interface faxi_burst_seq_if #(
  parameter int AW = 32,
  parameter int IW = 4
);
  logic          i_avalid;
  logic          o_aready;
  logic [AW-1:0] i_addr;
  logic [7:0]    i_len;
  logic [2:0]    i_size;
  logic [1:0]    i_burst;
  logic [IW-1:0] i_id;
  logic          o_bvalid;
  logic          i_bready;
  logic [AW-1:0] o_baddr;
  logic [IW-1:0] o_bid;
  logic [7:0]    o_bnum;
  logic          o_blast;
  logic [2:0]    o_bsize;
  logic          o_berr;

  modport slave (
    input  i_avalid, i_addr, i_len, i_size, i_burst, i_id, i_bready,
    output o_aready, o_bvalid, o_baddr, o_bid, o_bnum, o_blast, o_bsize, o_berr
  );

  modport master (
    output i_avalid, i_addr, i_len, i_size, i_burst, i_id, i_bready,
    input  o_aready, o_bvalid, o_baddr, o_bid, o_bnum, o_blast, o_bsize, o_berr
  );
endinterface

// File: rtl/faxi_burst_seq.sv
// AXI slave burst sequencer: one command in, one beat address per cycle out.
// Latency: command accepted at edge N shows beat 0 in cycle N+1; back-to-back bursts have no bubble.
// Backpressure: beat outputs hold while i_bready is low; o_aready is combinational on the last beat.
module faxi_burst_seq #(
  parameter int AW = 32,
  parameter int IW = 4,
  parameter int DW = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  faxi_burst_seq_if.slave   bus
);
  localparam int MAX_SIZE = $clog2(DW / 8);
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

  state_t        state_q;
  mode_t         mode_q;
  logic [7:0]    len_q;
  logic [AW-1:0] mask_q;
  logic          bvalid_q;
  logic [AW-1:0] baddr_q;
  logic [IW-1:0] bid_q;
  logic [7:0]    bnum_q;
  logic          blast_q;
  logic [2:0]    bsize_q;
  logic          berr_q;

  logic [AW-1:0] size_mask_in;
  logic [AW-1:0] wrap_mask_in;
  logic          is_wrap_in;
  logic          len_ok_in;
  logic          err_in;
  mode_t         mode_in;
  logic [AW-1:0] step;
  logic [AW-1:0] incr_next;
  logic [AW-1:0] next_addr;
  logic          aready;
  logic          accept;

  // Command decode: legality and the address mode actually used for beats.
  always_comb begin
    size_mask_in = (ONE << bus.i_size) - ONE;
    wrap_mask_in = ((AW'(bus.i_len) + ONE) << bus.i_size) - ONE;
    is_wrap_in   = (bus.i_burst == 2'b10);
    len_ok_in    = (bus.i_len == 8'd1) || (bus.i_len == 8'd3) ||
                   (bus.i_len == 8'd7) || (bus.i_len == 8'd15);
    err_in       = (bus.i_burst == 2'b11) ||
                   (is_wrap_in && !len_ok_in) ||
                   (is_wrap_in && ((bus.i_addr & size_mask_in) != '0)) ||
                   (int'(bus.i_size) > MAX_SIZE);
    if (bus.i_burst == 2'b00)
      mode_in = M_FIXED;
    else if (is_wrap_in && !err_in)
      mode_in = M_WRAP;
    else
      mode_in = M_INCR;
  end

  // Per-beat address step from the latched command.
  always_comb begin
    step      = ONE << bsize_q;
    incr_next = (baddr_q + step) & ~(step - ONE);
    case (mode_q)
      M_FIXED: next_addr = baddr_q;
      M_WRAP:  next_addr = (baddr_q & ~mask_q) | (incr_next & mask_q);
      default: next_addr = incr_next;
    endcase
  end

  assign aready = (state_q == IDLE) || (blast_q && bus.i_bready);
  assign accept = bus.i_avalid && aready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      mode_q   <= M_FIXED;
      len_q    <= '0;
      mask_q   <= '0;
      bvalid_q <= 1'b0;
      baddr_q  <= '0;
      bid_q    <= '0;
      bnum_q   <= '0;
      blast_q  <= 1'b0;
      bsize_q  <= '0;
      berr_q   <= 1'b0;
    end else begin
      if (state_q == BURST && bus.i_bready) begin
        if (!blast_q) begin
          bnum_q  <= bnum_q + 8'd1;
          baddr_q <= next_addr;
          blast_q <= ((bnum_q + 8'd1) == len_q);
        end else begin
          state_q  <= IDLE;
          bvalid_q <= 1'b0;
        end
      end
      // A new command overrides the completion above, giving zero-bubble chaining.
      if (accept) begin
        state_q  <= BURST;
        bvalid_q <= 1'b1;
        mode_q   <= mode_in;
        len_q    <= bus.i_len;
        mask_q   <= wrap_mask_in;
        baddr_q  <= bus.i_addr;
        bid_q    <= bus.i_id;
        bnum_q   <= 8'd0;
        blast_q  <= (bus.i_len == 8'd0);
        bsize_q  <= bus.i_size;
        berr_q   <= err_in;
      end
    end
  end

  assign bus.o_aready = aready;
  assign bus.o_bvalid = bvalid_q;
  assign bus.o_baddr  = baddr_q;
  assign bus.o_bid    = bid_q;
  assign bus.o_bnum   = bnum_q;
  assign bus.o_blast  = blast_q;
  assign bus.o_bsize  = bsize_q;
  assign bus.o_berr   = berr_q;
endmodule

// File: tb/tb_faxi_burst_seq.sv
// Directed bench for faxi_burst_seq: wrap/incr/fixed address sequences, chaining, illegal commands, reset.
module tb_faxi_burst_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  faxi_burst_seq_if #(.AW(32), .IW(4)) bus ();

  faxi_burst_seq #(.AW(32), .IW(4), .DW(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input int n, input bit last,
                      input bit err, input logic [3:0] id, input logic [2:0] sz);
    chk({tag, ".vld"},  64'(bus.o_bvalid), 64'd1);
    chk({tag, ".addr"}, 64'(bus.o_baddr), 64'(a));
    chk({tag, ".num"},  64'(bus.o_bnum), 64'(n));
    chk({tag, ".last"}, 64'(bus.o_blast), 64'(last));
    chk({tag, ".err"},  64'(bus.o_berr), 64'(err));
    chk({tag, ".id"},   64'(bus.o_bid), 64'(id));
    chk({tag, ".size"}, 64'(bus.o_bsize), 64'(sz));
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, ".aready"}, 64'(bus.o_aready), 64'd1);
    chk({tag, ".bvalid"}, 64'(bus.o_bvalid), 64'd0);
    chk({tag, ".baddr"},  64'(bus.o_baddr), 64'd0);
    chk({tag, ".bid"},    64'(bus.o_bid), 64'd0);
    chk({tag, ".bnum"},   64'(bus.o_bnum), 64'd0);
    chk({tag, ".blast"},  64'(bus.o_blast), 64'd0);
    chk({tag, ".bsize"},  64'(bus.o_bsize), 64'd0);
    chk({tag, ".berr"},   64'(bus.o_berr), 64'd0);
  endtask

  // Drive a command at the current negedge; it is accepted at the next posedge.
  task automatic cmd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                     input logic [1:0] bt, input logic [3:0] id);
    bus.i_avalid = 1'b1;
    bus.i_addr   = a;
    bus.i_len    = len;
    bus.i_size   = sz;
    bus.i_burst  = bt;
    bus.i_id     = id;
  endtask

  // Issue one command, then walk its beats with i_bready held high.
  task automatic run(input string tag, input logic [31:0] a, input logic [7:0] len,
                     input logic [2:0] sz, input logic [1:0] bt, input logic [3:0] id,
                     input logic [31:0] exp_a [], input bit err);
    cmd(a, len, sz, bt, id);
    bus.i_bready = 1'b1;
    tick();
    bus.i_avalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      beat($sformatf("%s.b%0d", tag, i), exp_a[i], i, i == int'(len), err, id, sz);
      tick();
    end
    chk({tag, ".done_vld"}, 64'(bus.o_bvalid), 64'd0);
    chk({tag, ".done_rdy"}, 64'(bus.o_aready), 64'd1);
  endtask

  initial begin
    logic [31:0] ea [];
    int  exp_n;
    int  cyc;
    bit  done;
    bit  rdy;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.i_avalid = 1'b0;
    bus.i_addr   = '0;
    bus.i_len    = '0;
    bus.i_size   = '0;
    bus.i_burst  = '0;
    bus.i_id     = '0;
    bus.i_bready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_vals("rst");
    rst = 1'b0;

    // WRAP 124, size 4B, 8 beats: 32-byte window starting at 96.
    ea = '{32'd124, 32'd96, 32'd100, 32'd104, 32'd108, 32'd112, 32'd116, 32'd120};
    run("wrap", 32'd124, 8'd7, 3'd2, 2'b10, 4'd3, ea, 1'b0);

    ea = '{32'h13, 32'h14, 32'h18, 32'h1C};
    run("incr_ua", 32'h13, 8'd3, 3'd2, 2'b01, 4'd4, ea, 1'b0);

    ea = '{32'hFFFF_FFFC, 32'h0000_0000};
    run("incr_wrap32", 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 4'd6, ea, 1'b0);

    // FIXED with random stalls; size 3 exceeds the 32-bit bus so berr is set.
    cmd(32'h40, 8'd4, 3'd3, 2'b00, 4'd7);
    tick();
    bus.i_avalid = 1'b0;
    exp_n = 0;
    cyc   = 0;
    done  = 1'b0;
    while (!done && cyc < 200) begin
      beat($sformatf("fixed.c%0d", cyc), 32'h40, exp_n, exp_n == 4, 1'b1, 4'd7, 3'd3);
      rdy = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.i_bready = rdy;
      tick();
      cyc++;
      if (rdy) begin
        if (exp_n == 4) done = 1'b1;
        else exp_n++;
      end
    end
    chk("fixed.finished", 64'(done), 64'd1);
    chk("fixed.done_vld", 64'(bus.o_bvalid), 64'd0);
    bus.i_bready = 1'b1;

    // Back-to-back: INCR len1 id1 chained into WRAP len3 id2 with no bubble.
    cmd(32'h200, 8'd1, 3'd2, 2'b01, 4'd1);
    tick();
    beat("b2b.a0", 32'h200, 0, 1'b0, 1'b0, 4'd1, 3'd2);
    chk("b2b.a0.aready", 64'(bus.o_aready), 64'd0);
    cmd(32'h308, 8'd3, 3'd2, 2'b10, 4'd2);
    tick();
    beat("b2b.a1", 32'h204, 1, 1'b1, 1'b0, 4'd1, 3'd2);
    chk("b2b.a1.aready", 64'(bus.o_aready), 64'd1);
    tick();
    bus.i_avalid = 1'b0;
    ea = '{32'h308, 32'h30C, 32'h300, 32'h304};
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("b2b.w%0d", i), ea[i], i, i == 3, 1'b0, 4'd2, 3'd2);
      tick();
    end
    chk("b2b.done_vld", 64'(bus.o_bvalid), 64'd0);

    // Illegal WRAP length runs as INCR with berr; reserved burst likewise.
    ea = '{32'h100, 32'h104, 32'h108};
    run("ill_wrap", 32'h100, 8'd2, 3'd2, 2'b10, 4'd8, ea, 1'b1);
    ea = '{32'h10, 32'h14};
    run("ill_rsv", 32'h10, 8'd1, 3'd2, 2'b11, 4'd9, ea, 1'b1);

    // Reset at beat 3 of a 16-beat INCR aborts the burst.
    cmd(32'h1000, 8'd15, 3'd2, 2'b01, 4'd10);
    tick();
    bus.i_avalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("abort.b%0d", i), 32'h1000 + 32'(4 * i), i, 1'b0, 1'b0, 4'd10, 3'd2);
      if (i == 3) rst = 1'b1;
      tick();
    end
    reset_vals("abort");
    rst = 1'b0;
    tick();
    chk("abort.idle_vld", 64'(bus.o_bvalid), 64'd0);

    ea = '{32'h50};
    run("post_rst", 32'h50, 8'd0, 3'd2, 2'b01, 4'd5, ea, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
